// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers and read-latency constants for the FIFO slice
// Contents:
//   clog2    - ceiling log2 of a positive integer
//   depth    - number of words for a given address width
//   RD_LAT_* - read latency selected by OUTPUT_REG
package fifo_pkg;

    localparam int RD_LAT_1 = 1;
    localparam int RD_LAT_2 = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++)
            if ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: simple dual-port RAM, synchronous write, registered read, no reset
// Ports:
//   clk              - clock
//   wr_en/wr_addr/wr_data - write port
//   rd_en/rd_addr    - read request; rd_data updates on the edge rd_en is sampled
//   rd_data          - registered read word, held while rd_en is low
module sync_fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [depth(ADDR_WIDTH)];

    always_ff @(posedge clk) begin
        if (wr_en) r_mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= r_mem[rd_addr];
    end

endmodule

// File: rtl/sync_fifo_ctrl_param.sv
// sync_fifo_ctrl_param: parametrised single-clock FIFO with level, flush and sticky error flags
// Ports:
//   clk, tb_rst (async, active-high), flush (sync clear)
//   wr_en/wr_data, wr_full, almost_full        - write side
//   rd_en, rd_data/rd_valid, rd_empty, almost_empty - read side
//   water_level                                - occupancy 0..DEPTH
//   overflow/underflow                         - sticky until flush or reset
module sync_fifo_ctrl_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH       = 64,
    parameter int ADDR_WIDTH       = 6,
    parameter int ALMOST_FULL_NUM  = 63,
    parameter int ALMOST_EMPTY_NUM = 4,
    parameter int OUTPUT_REG       = 0
) (
    input  logic                  clk,
    input  logic                  tb_rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   water_level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH  = depth(ADDR_WIDTH);
    localparam int                RD_LAT = (OUTPUT_REG != 0) ? RD_LAT_2 : RD_LAT_1;
    localparam logic [ADDR_WIDTH:0] AF   = (ADDR_WIDTH+1)'(ALMOST_FULL_NUM);
    localparam logic [ADDR_WIDTH:0] AE   = (ADDR_WIDTH+1)'(ALMOST_EMPTY_NUM);

    if (ALMOST_FULL_NUM < 1 || ALMOST_FULL_NUM > DEPTH ||
        ALMOST_EMPTY_NUM < 0 || ALMOST_EMPTY_NUM > DEPTH - 1 ||
        OUTPUT_REG < 0 || OUTPUT_REG > 1 || clog2(DEPTH) != ADDR_WIDTH) begin : g_param_err
        $error("sync_fifo_ctrl_param: ALMOST_*/OUTPUT_REG parameter out of range");
    end

    logic [ADDR_WIDTH:0]   r_wr_ptr, r_rd_ptr, r_count;
    logic [1:0]            r_vld;
    logic                  r_hold, r_ovf, r_udf;
    logic [DATA_WIDTH-1:0] r_rd_data, w_ram_q;
    logic                  w_wr, w_rd;

    assign wr_full      = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]) &&
                          (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);
    assign rd_empty     = r_wr_ptr == r_rd_ptr;
    assign almost_full  = r_count >= AF;
    assign almost_empty = r_count <= AE;
    assign water_level  = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;
    // flush wins over both requests, so neither pointer nor RAM moves on a flush edge
    assign w_wr         = wr_en && !wr_full && !flush;
    assign w_rd         = rd_en && !rd_empty && !flush;
    assign rd_valid     = (RD_LAT == RD_LAT_2) ? r_vld[1] : r_vld[0];
    // the RAM output register has no reset, so mask it until a word has actually been read
    assign rd_data      = (RD_LAT == RD_LAT_2) ? r_rd_data : (r_hold ? w_ram_q : '0);

    sync_fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .wr_en  (w_wr),
        .wr_addr(r_wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data(wr_data),
        .rd_en  (w_rd),
        .rd_addr(r_rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data(w_ram_q)
    );

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_vld     <= '0;
            r_hold    <= 1'b0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
            r_rd_data <= '0;
        end else if (flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_vld     <= '0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (ADDR_WIDTH+1)'(w_wr) - (ADDR_WIDTH+1)'(w_rd);
            r_vld   <= {r_vld[0], w_rd};
            if (w_rd) r_hold <= 1'b1;
            if (r_vld[0]) r_rd_data <= w_ram_q;
            if (wr_en && wr_full) r_ovf <= 1'b1;
            if (rd_en && rd_empty) r_udf <= 1'b1;
        end
    end

endmodule
